// File: rtl/ws2812_rx_decoder_if.sv
// Signal bundle between the WS2812 serial line and the decoder's word/frame outputs.
// The decoder takes the master side; whoever drives the line and consumes words takes slave.
interface ws2812_rx_decoder_if #(
  parameter int PIX_W = 8
);
  logic             din;
  logic [23:0]      rgb_data;
  logic             rgb_valid;
  logic             frame_start;
  logic             frame_done;
  logic [PIX_W-1:0] pixel_cnt;
  logic             err;
  logic             busy;

  modport master (
    input  din,
    output rgb_data, rgb_valid, frame_start, frame_done, pixel_cnt, err, busy
  );

  modport slave (
    output din,
    input  rgb_data, rgb_valid, frame_start, frame_done, pixel_cnt, err, busy
  );
endinterface

// File: rtl/ws2812_rx_decoder.sv
// WS2812 NRZ receiver: decodes bits by high-pulse width into MSB-first 24-bit words,
// with frame start/end detection on the reset gap and protocol error reporting.
module ws2812_rx_decoder #(
  parameter int BIT_THRESH = 30,
  parameter int MIN_HIGH   = 5,
  parameter int MAX_HIGH   = 100,
  parameter int RESET_CYC  = 2500,
  parameter int PIX_W      = 8
) (
  input logic                 clk,
  input logic                 rst,
  ws2812_rx_decoder_if.master bus
);

  localparam int HW = $clog2(MAX_HIGH + 1);
  localparam int LW = $clog2(RESET_CYC + 1);

  localparam logic [HW-1:0]    H_ONE = {{(HW-1){1'b0}}, 1'b1};
  localparam logic [HW-1:0]    H_MAX = HW'(MAX_HIGH);
  localparam logic [HW-1:0]    H_MIN = HW'(MIN_HIGH);
  localparam logic [HW-1:0]    H_THR = HW'(BIT_THRESH);
  localparam logic [LW-1:0]    L_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]    L_MAX = LW'(RESET_CYC);
  localparam logic [PIX_W-1:0] P_ONE = {{(PIX_W-1){1'b0}}, 1'b1};
  localparam logic [PIX_W-1:0] P_MAX = {PIX_W{1'b1}};

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic             d1_r, d2_r, d3_r;
  logic             rise_s, fall_s, bit_s;
  logic [HW-1:0]    hcnt_r, hcnt_s;
  logic [LW-1:0]    lcnt_r, lcnt_s;
  logic [23:0]      shift_r, shift_s;
  logic [4:0]       bit_cnt_r, bit_cnt_s;
  logic [23:0]      rgb_data_r, rgb_data_s;
  logic [PIX_W-1:0] pixel_cnt_r, pixel_cnt_s;
  logic             rgb_valid_r, rgb_valid_s;
  logic             frame_start_r, frame_start_s;
  logic             frame_done_r, frame_done_s;
  logic             err_r, err_s;
  logic             busy_r, busy_s;

  // Two-flop synchroniser for the asynchronous line plus one delay stage for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_r <= 1'b0;
      d2_r <= 1'b0;
      d3_r <= 1'b0;
    end else begin
      d1_r <= bus.din;
      d2_r <= d1_r;
      d3_r <= d2_r;
    end
  end

  assign rise_s = d2_r & ~d3_r;
  assign fall_s = ~d2_r & d3_r;

  // hcnt includes the current high cycle and holds through the low phase so the fall
  // cycle still sees the completed pulse width; both counters saturate.
  assign hcnt_s = d2_r ? (d3_r ? ((hcnt_r == H_MAX) ? hcnt_r : hcnt_r + H_ONE) : H_ONE)
                       : hcnt_r;
  assign lcnt_s = d2_r ? {LW{1'b0}} : ((lcnt_r == L_MAX) ? lcnt_r : lcnt_r + L_ONE);
  assign bit_s  = (hcnt_r >= H_THR);

  // Next-state and next-output decode
  always_comb begin
    state_s       = state_r;
    shift_s       = shift_r;
    bit_cnt_s     = bit_cnt_r;
    rgb_data_s    = rgb_data_r;
    pixel_cnt_s   = pixel_cnt_r;
    busy_s        = busy_r;
    rgb_valid_s   = 1'b0;
    frame_start_s = 1'b0;
    frame_done_s  = 1'b0;
    err_s         = 1'b0;

    case (state_r)
      SYNC: begin
        if (lcnt_s == L_MAX) begin
          state_s = ARMED;
        end else begin
          state_s = SYNC;
        end
      end
      ARMED: begin
        if (rise_s) begin
          state_s       = HIGH;
          frame_start_s = 1'b1;
          busy_s        = 1'b1;
          pixel_cnt_s   = {PIX_W{1'b0}};
          bit_cnt_s     = 5'd0;
          shift_s       = 24'd0;
        end else begin
          state_s = ARMED;
        end
      end
      HIGH: begin
        if (d2_r && (hcnt_s == H_MAX)) begin
          state_s = SYNC;
          err_s   = 1'b1;
          busy_s  = 1'b0;
        end else if (fall_s && (hcnt_r < H_MIN)) begin
          state_s = SYNC;
          err_s   = 1'b1;
          busy_s  = 1'b0;
        end else if (fall_s) begin
          state_s = GAP;
          shift_s = {shift_r[22:0], bit_s};
          if (bit_cnt_r == 5'd23) begin
            rgb_data_s  = {shift_r[22:0], bit_s};
            rgb_valid_s = 1'b1;
            bit_cnt_s   = 5'd0;
            pixel_cnt_s = (pixel_cnt_r == P_MAX) ? pixel_cnt_r : pixel_cnt_r + P_ONE;
          end else begin
            bit_cnt_s = bit_cnt_r + 5'd1;
          end
        end else begin
          state_s = HIGH;
        end
      end
      GAP: begin
        if (rise_s) begin
          state_s = HIGH;
        end else if (lcnt_s == L_MAX) begin
          // A leftover partial word is dropped; rgb_data keeps the last full word.
          state_s      = ARMED;
          frame_done_s = 1'b1;
          busy_s       = 1'b0;
          err_s        = (bit_cnt_r != 5'd0);
        end else begin
          state_s = GAP;
        end
      end
      default: begin
        state_s = SYNC;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= SYNC;
      hcnt_r        <= {HW{1'b0}};
      lcnt_r        <= {LW{1'b0}};
      shift_r       <= 24'd0;
      bit_cnt_r     <= 5'd0;
      rgb_data_r    <= 24'd0;
      pixel_cnt_r   <= {PIX_W{1'b0}};
      rgb_valid_r   <= 1'b0;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      err_r         <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      hcnt_r        <= hcnt_s;
      lcnt_r        <= lcnt_s;
      shift_r       <= shift_s;
      bit_cnt_r     <= bit_cnt_s;
      rgb_data_r    <= rgb_data_s;
      pixel_cnt_r   <= pixel_cnt_s;
      rgb_valid_r   <= rgb_valid_s;
      frame_start_r <= frame_start_s;
      frame_done_r  <= frame_done_s;
      err_r         <= err_s;
      busy_r        <= busy_s;
    end
  end

  assign bus.rgb_data    = rgb_data_r;
  assign bus.rgb_valid   = rgb_valid_r;
  assign bus.frame_start = frame_start_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.pixel_cnt   = pixel_cnt_r;
  assign bus.err         = err_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Scoreboard bench for ws2812_rx_decoder: expected words and frame-end results are queued
// as the line is driven and checked when the decoder strobes them.
module tb_ws2812_rx_decoder;

  typedef struct {
    int pix;
    bit err;
  } done_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_start;
  int   n_err;
  int   n_valid;

  logic [23:0] exp_q[$];
  done_t       done_q[$];

  ws2812_rx_decoder_if #(.PIX_W(8)) bus ();

  ws2812_rx_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: compare every strobe against what the stimulus queued
  always @(negedge clk) begin
    if (bus.rgb_valid) begin
      n_valid++;
      if (exp_q.size() > 0) check_eq("rgb_data", 32'(bus.rgb_data), 32'(exp_q.pop_front()));
      else check_eq("rgb_spurious", 32'(bus.rgb_valid), 32'(1'b0));
    end
    if (bus.frame_done) begin
      if (done_q.size() > 0) begin
        done_t d;
        d = done_q.pop_front();
        check_eq("done_pix", 32'(bus.pixel_cnt), 32'(d.pix));
        check_eq("done_err", 32'(bus.err), 32'(d.err));
      end else begin
        check_eq("done_spurious", 32'(bus.frame_done), 32'(1'b0));
      end
    end
    if (bus.frame_start) n_start++;
    if (bus.err) n_err++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input int hi, input int period);
    bus.din = 1'b1;
    tick(hi);
    bus.din = 1'b0;
    tick(period - hi);
  endtask

  task automatic send_bits(input logic [23:0] w, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) send_bit(w[i] ? 35 : 18, 62);
  endtask

  task automatic send_word(input logic [23:0] w, input bit expect_word);
    if (expect_word) exp_q.push_back(w);
    send_bits(w, 24);
  endtask

  task automatic expect_done(input int pix, input bit e);
    done_t d;
    d.pix = pix;
    d.err = e;
    done_q.push_back(d);
  endtask

  task automatic gap();
    bus.din = 1'b0;
    tick(2600);
  endtask

  initial begin
    int          s0;
    int          e0;
    logic [21:0] rest;
    logic [23:0] last_word;
    n_checks = 0;
    n_errors = 0;
    n_start  = 0;
    n_err    = 0;
    n_valid  = 0;
    rst      = 1'b1;
    bus.din  = 1'b0;
    tick(5);
    check_eq("reset_data", {bus.rgb_data, bus.pixel_cnt}, 32'd0);
    check_eq("reset_flags", 32'({bus.rgb_valid, bus.frame_start, bus.frame_done, bus.err, bus.busy}), 32'd0);
    rst = 1'b0;
    gap();

    // single word frame
    s0 = n_start;
    expect_done(1, 1'b0);
    send_word(24'hFF00FF, 1'b1);
    check_eq("busy_in_frame", 32'(bus.busy), 32'd1);
    gap();
    check_eq("t1_starts", 32'(n_start - s0), 32'd1);
    check_eq("t1_no_err", 32'(n_err), 32'd0);
    check_eq("t1_idle", 32'(bus.busy), 32'd0);

    // four words in one frame
    expect_done(4, 1'b0);
    send_word(24'h00FF00, 1'b1);
    send_word(24'hAA55AA, 1'b1);
    send_word(24'hA543D5, 1'b1);
    send_word(24'hA543D5, 1'b1);
    gap();
    check_eq("pix_hold", 32'(bus.pixel_cnt), 32'd4);

    // threshold boundary: 29 cycles -> 0, 30 cycles -> 1
    rest      = 22'h2AAAAA;
    last_word = 24'h6AAAAA;
    exp_q.push_back(last_word);
    expect_done(1, 1'b0);
    send_bit(29, 62);
    send_bit(30, 62);
    for (int i = 21; i >= 0; i--) send_bit(rest[i] ? 35 : 18, 62);
    gap();
    check_eq("thresh_word", 32'(bus.rgb_data), 32'(last_word));

    // glitch mid-word, then a word that must be ignored until a full gap
    s0 = n_start;
    e0 = n_err;
    send_bits(24'hAAAAAA, 5);
    send_bit(3, 62);
    check_eq("glitch_err", 32'(n_err - e0), 32'd1);
    check_eq("glitch_busy", 32'(bus.busy), 32'd0);
    send_word(24'h123456, 1'b0);
    gap();
    check_eq("glitch_starts", 32'(n_start - s0), 32'd1);

    // partial word at frame end
    e0 = n_err;
    expect_done(0, 1'b1);
    send_bits(24'h5A5A5A, 10);
    gap();
    check_eq("partial_keep", 32'(bus.rgb_data), 32'(last_word));
    check_eq("partial_err", 32'(n_err - e0), 32'd1);

    // a 99-cycle high is a valid 1, a 100-cycle high is stuck
    e0 = n_err;
    send_bit(99, 130);
    check_eq("high99_ok", 32'(n_err - e0), 32'd0);
    bus.din = 1'b1;
    tick(100);
    bus.din = 1'b0;
    tick(10);
    check_eq("stuck_err", 32'(n_err - e0), 32'd1);
    check_eq("stuck_busy", 32'(bus.busy), 32'd0);
    gap();

    // reset mid-frame at bit 12
    send_bits(24'hC3C3C3, 12);
    bus.din = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(2);
    check_eq("midrst_data", {bus.rgb_data, bus.pixel_cnt}, 32'd0);
    check_eq("midrst_flags", 32'({bus.rgb_valid, bus.frame_start, bus.frame_done, bus.err, bus.busy}), 32'd0);
    rst = 1'b0;
    send_word(24'hDEAD00, 1'b0);
    gap();
    expect_done(1, 1'b0);
    send_word(24'h0F1E2D, 1'b1);
    gap();

    check_eq("total_starts", 32'(n_start), 32'd8);
    check_eq("total_errs", 32'(n_err), 32'd3);
    check_eq("total_valid", 32'(n_valid), 32'd7);
    check_eq("word_q_left", 32'(exp_q.size()), 32'd0);
    check_eq("done_q_left", 32'(done_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
